// File: rtl/mioc_gate_tester_pkg.sv
// Shared types and constants for the MIOC 2-input gate tester.
// Holds the sequencer state encoding and the expected-z tables of common gates.
`timescale 1ns/1ps
package mioc_gate_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bit k is the expected z for pattern index k = {in1, in2}.
    localparam logic [3:0] TRUTH_NOR2  = 4'b0001;
    localparam logic [3:0] TRUTH_NAND2 = 4'b0111;

    function automatic logic is_busy(input state_t s);
        return (s == ST_APPLY) || (s == ST_SETTLE) || (s == ST_SAMPLE);
    endfunction

endpackage

// File: rtl/mioc_gate_tester_sync2.sv
// Two-flop synchronizer for a single asynchronous pad input.
// Both flops clear on reset so the synchronized value starts at 0.
`timescale 1ns/1ps
module mioc_gate_tester_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mioc_gate_tester.sv
// On-chip sequencer that walks a 2-input gate through all four input patterns,
// samples its synchronized output after a settle delay and scores it against TRUTH.
`timescale 1ns/1ps
module mioc_gate_tester
    import mioc_gate_tester_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 10,
    parameter logic [3:0] TRUTH         = TRUTH_NOR2,
    parameter int         CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       in1,
    output logic       in2,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] result_vec,
    output logic       sample_valid,
    output logic [1:0] sample_idx,
    output logic       sample_z
);

    state_t             state, state_next;
    logic [1:0]         idx, idx_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               z_s;
    logic               in1_next, in2_next, busy_next, done_next, pass_next;
    logic               sample_valid_next, sample_z_next;
    logic [2:0]         err_next;
    logic [3:0]         result_next;
    logic [1:0]         sample_idx_next;

    mioc_gate_tester_sync2 u_sync_z (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (z),
        .q     (z_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        idx_next          = idx;
        cnt_next          = cnt;
        in1_next          = in1;
        in2_next          = in2;
        err_next          = err_count;
        result_next       = result_vec;
        sample_valid_next = 1'b0;
        sample_idx_next   = sample_idx;
        sample_z_next     = sample_z;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_next    = '0;
                    result_next = '0;
                    idx_next    = '0;
                    state_next  = ST_APPLY;
                end
            end
            ST_APPLY: begin
                in1_next   = idx[1];
                in2_next   = idx[0];
                cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_next = ST_SAMPLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_SAMPLE: begin
                result_next[idx]  = z_s;
                sample_z_next     = z_s;
                sample_idx_next   = idx;
                sample_valid_next = 1'b1;
                // At most four samples per run, so the 3-bit count cannot wrap.
                if (z_s != TRUTH[idx]) begin
                    err_next = err_count + 3'd1;
                end
                if (idx == 2'd3) begin
                    in1_next   = 1'b0;
                    in2_next   = 1'b0;
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx + 2'd1;
                    state_next = ST_APPLY;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        busy_next = is_busy(state_next);
        done_next = (state_next == ST_DONE);
        pass_next = done_next && (err_next == 3'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            cnt          <= '0;
            in1          <= 1'b0;
            in2          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            result_vec   <= '0;
            sample_valid <= 1'b0;
            sample_idx   <= '0;
            sample_z     <= 1'b0;
        end else begin
            idx          <= idx_next;
            cnt          <= cnt_next;
            in1          <= in1_next;
            in2          <= in2_next;
            busy         <= busy_next;
            done         <= done_next;
            pass         <= pass_next;
            err_count    <= err_next;
            result_vec   <= result_next;
            sample_valid <= sample_valid_next;
            sample_idx   <= sample_idx_next;
            sample_z     <= sample_z_next;
        end
    end

endmodule
